fitness_wb_collector: RTL and testbench

//  Consumes fitness_eval results (energy, individual, write-back index) and stores them in a per-generation

---
 rtl/fitness_wb_collector.sv | 136 +++++++++++++
 tb/tb_fitness_wb_collector.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fitness_wb_collector.sv
// Collects fitness_eval results into a per-generation register file and tracks the best individual.
// Latency: a write lands at the clock edge that samples it; a read returns data one cycle after rd_en_i.
// Backpressure: none. One write and one read are accepted every cycle, and fitness_eval never stalls.
// Ports: clk_i/rst_n (async, active-low); gen_start_i opens a generation; in_valid_i/energy_i/
//   individual_vec_i/ind_idx_i form the write port; rd_en_i/rd_idx_i -> rd_*_ff_o form the registered
//   read port; best_*_ff_o, collected_cnt_ff_o, gen_done_ff_o, busy_o and idx_err_ff_o give status.
module fitness_wb_collector #(
  parameter int SELF_FIT_LENGTH   = 10,
  parameter int INDIVIDUAL_LENGTH = 22,
  parameter int POP_SIZE          = 50,
  parameter int IDX_WIDTH         = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_n,
  input  logic                         gen_start_i,
  input  logic                         in_valid_i,
  input  logic [SELF_FIT_LENGTH-1:0]   energy_i,
  input  logic [INDIVIDUAL_LENGTH-1:0] individual_vec_i,
  input  logic [IDX_WIDTH-1:0]         ind_idx_i,
  input  logic                         rd_en_i,
  input  logic [IDX_WIDTH-1:0]         rd_idx_i,
  output logic                         rd_valid_ff_o,
  output logic [SELF_FIT_LENGTH-1:0]   rd_energy_ff_o,
  output logic [INDIVIDUAL_LENGTH-1:0] rd_individual_ff_o,
  output logic [SELF_FIT_LENGTH-1:0]   best_energy_ff_o,
  output logic [INDIVIDUAL_LENGTH-1:0] best_individual_ff_o,
  output logic [IDX_WIDTH-1:0]         best_idx_ff_o,
  output logic [IDX_WIDTH-1:0]         collected_cnt_ff_o,
  output logic                         gen_done_ff_o,
  output logic                         busy_o,
  output logic                         idx_err_ff_o
);

  localparam int AW = (POP_SIZE > 1) ? $clog2(POP_SIZE) : 1;
  localparam int DW = SELF_FIT_LENGTH + INDIVIDUAL_LENGTH;
  localparam logic [IDX_WIDTH-1:0] POP_IDX  = IDX_WIDTH'(POP_SIZE);
  localparam logic [IDX_WIDTH-1:0] POP_LAST = IDX_WIDTH'(POP_SIZE - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]          state_ff;
  logic [DW-1:0]       mem_ff [POP_SIZE];
  logic [POP_SIZE-1:0] bitmap_ff;

  logic          wr_in_range;
  logic          rd_in_range;
  logic [AW-1:0] wr_a;
  logic [AW-1:0] rd_a;
  logic          do_wr;

  assign wr_in_range = (ind_idx_i < POP_IDX);
  assign rd_in_range = (rd_idx_i < POP_IDX);
  assign wr_a        = ind_idx_i[AW-1:0];
  assign rd_a        = rd_idx_i[AW-1:0];
  // A simultaneous gen_start_i takes priority, so the sample presented in that cycle is dropped.
  assign do_wr       = (state_ff == COLLECT) && in_valid_i && !gen_start_i && wr_in_range;
  assign busy_o      = (state_ff == COLLECT);

  // Control, bitmap and best tracking.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_ff             <= IDLE;
      bitmap_ff            <= '0;
      collected_cnt_ff_o   <= '0;
      best_energy_ff_o     <= '1;
      best_individual_ff_o <= '0;
      best_idx_ff_o        <= '0;
      gen_done_ff_o        <= 1'b0;
      idx_err_ff_o         <= 1'b0;
    end else begin
      gen_done_ff_o <= 1'b0;
      if (gen_start_i) begin
        // Opening a generation also aborts one in progress; no done pulse is raised.
        state_ff             <= COLLECT;
        bitmap_ff            <= '0;
        collected_cnt_ff_o   <= '0;
        best_energy_ff_o     <= '1;
        best_individual_ff_o <= '0;
        best_idx_ff_o        <= '0;
        idx_err_ff_o         <= 1'b0;
      end else if (state_ff == COLLECT && in_valid_i) begin
        if (wr_in_range) begin
          if (!bitmap_ff[wr_a]) begin
            bitmap_ff[wr_a]    <= 1'b1;
            collected_cnt_ff_o <= collected_cnt_ff_o + 1'b1;
            if (collected_cnt_ff_o == POP_LAST) begin
              state_ff      <= DONE;
              gen_done_ff_o <= 1'b1;
            end
          end
          // Strict compare: ties keep the earlier holder, and a worse overwrite of the
          // best slot leaves the recorded best untouched.
          if (energy_i < best_energy_ff_o) begin
            best_energy_ff_o     <= energy_i;
            best_individual_ff_o <= individual_vec_i;
            best_idx_ff_o        <= ind_idx_i;
          end
        end else begin
          idx_err_ff_o <= 1'b1;
        end
      end
    end
  end

  // Storage. It is deliberately kept across generations; only reset clears it.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < POP_SIZE; i++) mem_ff[i] <= '0;
    end else if (do_wr) begin
      mem_ff[wr_a] <= {energy_i, individual_vec_i};
    end
  end

  // Registered read port. It samples the array before this edge's write, which gives
  // read-before-write on a same-slot collision.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_ff_o      <= 1'b0;
      rd_energy_ff_o     <= '0;
      rd_individual_ff_o <= '0;
    end else begin
      rd_valid_ff_o <= rd_en_i;
      if (rd_en_i) begin
        if (rd_in_range) begin
          {rd_energy_ff_o, rd_individual_ff_o} <= mem_ff[rd_a];
        end else begin
          rd_energy_ff_o     <= '0;
          rd_individual_ff_o <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fitness_wb_collector.sv
module tb_fitness_wb_collector;

  localparam int POP = 50;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        gen_start, in_valid, rd_en;
  logic [9:0]  energy;
  logic [21:0] ind_vec;
  logic [7:0]  ind_idx, rd_idx;
  logic        rd_valid, gen_done, busy, idx_err;
  logic [9:0]  rd_energy, best_energy;
  logic [21:0] rd_ind, best_ind;
  logic [7:0]  best_idx, cnt;

  always #5 clk_i = ~clk_i;

  fitness_wb_collector dut (
    .clk_i               (clk_i),
    .rst_n               (rst_n),
    .gen_start_i         (gen_start),
    .in_valid_i          (in_valid),
    .energy_i            (energy),
    .individual_vec_i    (ind_vec),
    .ind_idx_i           (ind_idx),
    .rd_en_i             (rd_en),
    .rd_idx_i            (rd_idx),
    .rd_valid_ff_o       (rd_valid),
    .rd_energy_ff_o      (rd_energy),
    .rd_individual_ff_o  (rd_ind),
    .best_energy_ff_o    (best_energy),
    .best_individual_ff_o(best_ind),
    .best_idx_ff_o       (best_idx),
    .collected_cnt_ff_o  (cnt),
    .gen_done_ff_o       (gen_done),
    .busy_o              (busy),
    .idx_err_ff_o        (idx_err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a generation is a set of written slots plus a running minimum.
  logic [9:0]  m_e [POP];
  logic [21:0] m_v [POP];
  bit          written [POP];
  bit          collecting;
  logic [9:0]  x_be;
  logic [21:0] x_bv;
  logic [7:0]  x_bi;
  bit          x_done, x_err, x_rv;
  logic [9:0]  x_re;
  logic [21:0] x_rvec;

  function automatic int n_written();
    int n = 0;
    for (int i = 0; i < POP; i++) n += written[i] ? 1 : 0;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < POP; i++) begin
      m_e[i] = '0; m_v[i] = '0; written[i] = 1'b0;
    end
    collecting = 0; x_be = 10'h3ff; x_bv = '0; x_bi = '0;
    x_done = 0; x_err = 0; x_rv = 0; x_re = '0; x_rvec = '0;
  endtask

  task automatic model_step(input logic gs, input logic v, input logic [9:0] e, input logic [21:0] vec,
                            input logic [7:0] idx, input logic re, input logic [7:0] ridx);
    x_rv = re;
    if (re) begin
      if (ridx < POP) begin x_re = m_e[ridx]; x_rvec = m_v[ridx]; end
      else begin x_re = '0; x_rvec = '0; end
    end
    x_done = 0;
    if (gs) begin
      collecting = 1;
      for (int i = 0; i < POP; i++) written[i] = 1'b0;
      x_be = 10'h3ff; x_bv = '0; x_bi = '0; x_err = 0;
    end else if (collecting && v) begin
      if (idx < POP) begin
        m_e[idx] = e; m_v[idx] = vec;
        if (e < x_be) begin x_be = e; x_bv = vec; x_bi = idx; end
        if (!written[idx]) begin
          written[idx] = 1'b1;
          if (n_written() == POP) begin collecting = 0; x_done = 1; end
        end
      end else begin
        x_err = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("cnt", 32'(cnt), 32'(n_written()));
    chk("busy", 32'(busy), 32'(collecting));
    chk("done", 32'(gen_done), 32'(x_done));
    chk("err", 32'(idx_err), 32'(x_err));
    chk("best_e", 32'(best_energy), 32'(x_be));
    chk("best_v", 32'(best_ind), 32'(x_bv));
    chk("best_i", 32'(best_idx), 32'(x_bi));
    chk("rd_vld", 32'(rd_valid), 32'(x_rv));
    chk("rd_e", 32'(rd_energy), 32'(x_re));
    chk("rd_v", 32'(rd_ind), 32'(x_rvec));
  endtask

  task automatic cyc(input logic gs, input logic v, input logic [9:0] e, input logic [21:0] vec,
                     input logic [7:0] idx, input logic re, input logic [7:0] ridx);
    gen_start = gs; in_valid = v; energy = e; ind_vec = vec; ind_idx = idx;
    rd_en = re; rd_idx = ridx;
    @(posedge clk_i); #1;
    model_step(gs, v, e, vec, idx, re, ridx);
    check_all();
    gen_start = 0; in_valid = 0; rd_en = 0;
  endtask

  task automatic wr(input logic [7:0] idx, input logic [9:0] e);
    cyc(0, 1, e, 22'(32'h1000 + 32'(idx) * 7 + 32'(e)), idx, 0, 0);
  endtask

  task automatic start();
    cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    gen_start = 0; in_valid = 0; rd_en = 0; energy = 0; ind_vec = 0; ind_idx = 0; rd_idx = 0;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_all();
    chk("rst_best_e", 32'(best_energy), 32'h3ff);
    rst_n = 1;

    // Writes in IDLE are ignored without raising an error.
    wr(3, 12);
    chk("idle_cnt", 32'(cnt), 0);
    chk("idle_err", 32'(idx_err), 0);

    // Full generation, distinct minimum at slot 17.
    start();
    for (int i = 0; i < POP; i++) wr(8'(i), (i == 17) ? 10'd5 : 10'(100 + i));
    chk("t2_done", 32'(gen_done), 1);
    chk("t2_best_e", 32'(best_energy), 5);
    chk("t2_best_i", 32'(best_idx), 17);
    chk("t2_cnt", 32'(cnt), 50);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t2_done_once", 32'(gen_done), 0);

    // Duplicate writes, out-of-range index, tied minimum.
    start();
    wr(4, 40);
    wr(60, 1);
    chk("t4_err", 32'(idx_err), 1);
    chk("t4_cnt", 32'(cnt), 1);
    for (int i = 0; i < POP; i++) begin
      wr(8'(i), (i == 2 || i == 9) ? 10'd7 : (i == 4 ? 10'd90 : 10'(200 + i)));
      if (i < POP - 1) chk("t3_no_done", 32'(gen_done), 0);
    end
    chk("t3_cnt", 32'(cnt), 50);
    chk("t4_best_i", 32'(best_idx), 2);
    cyc(0, 0, 0, 0, 0, 1, 4);
    chk("t3_rd4", 32'(rd_energy), 90);
    cyc(0, 0, 0, 0, 0, 1, 70);
    chk("rd_oor", 32'(rd_energy), 0);

    // Read-before-write on the same slot.
    start();
    wr(8, 33);
    cyc(0, 1, 44, 22'h2a, 8, 1, 8);
    chk("t5_old", 32'(rd_energy), 33);
    cyc(0, 0, 0, 0, 0, 1, 8);
    chk("t5_new", 32'(rd_energy), 44);

    // Abort at 20 slots with a simultaneous sample, then async reset mid-generation.
    start();
    for (int i = 0; i < 20; i++) wr(8'(i), 10'(300 + i));
    cyc(1, 1, 1, 22'h5, 30, 0, 0);
    chk("t6_cnt", 32'(cnt), 0);
    chk("t6_best", 32'(best_energy), 32'h3ff);
    for (int i = 0; i < 10; i++) wr(8'(i), 10'(50 + i));
    cyc(0, 0, 0, 0, 0, 1, 3);
    rst_n = 0;
    #1;
    model_reset();
    check_all();
    chk("t6_rst_busy", 32'(busy), 0);
    @(posedge clk_i); #1;
    rst_n = 1;

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      logic gs;
      gs = collecting ? ($urandom_range(0, 599) == 0) : ($urandom_range(0, 15) == 0);
      cyc(gs, ($urandom_range(0, 3) != 0), 10'($urandom_range(0, 1023)), 22'($urandom),
          8'($urandom_range(0, 59)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 55)));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
